// File: rtl/rx_sample_sequencer.sv
// RX frame capture sequencer: qualifies a start at the sample-tick rate, captures a fixed
// window MSB-first, and holds it for the decoder under valid/ready while counting lost starts.
module rx_sample_sequencer #(
  parameter int SAMPLES    = 80,
  parameter int QUAL_TICKS = 1,
  parameter int DROP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               rx_signal,
  input  logic               arm,
  input  logic               frame_ready,
  output logic [SAMPLES-1:0] frame_data,
  output logic               frame_valid,
  output logic               busy,
  output logic [7:0]         sample_count,
  output logic               overrun,
  output logic [DROP_W-1:0]  drop_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HUNT    = 3'd1;
  localparam logic [2:0] QUAL    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  localparam logic [7:0] FULL_COUNT = 8'(SAMPLES);
  localparam logic [7:0] QUAL_COUNT = 8'(QUAL_TICKS);

  logic [2:0]         state_reg, state_next;
  logic [SAMPLES-1:0] frame_data_reg, frame_data_next;
  logic               frame_valid_reg, frame_valid_next;
  logic [7:0]         sample_count_reg, sample_count_next;
  logic               overrun_reg, overrun_next;
  logic [DROP_W-1:0]  drop_count_reg, drop_count_next;
  logic               prev_rx_reg;
  logic               start_frame, store_en, clear_frame;
  logic [7:0]         count_inc;

  assign count_inc = (sample_count_reg == FULL_COUNT) ? sample_count_reg : sample_count_reg + 8'd1;

  always_comb begin
    state_next        = state_reg;
    frame_valid_next  = frame_valid_reg;
    sample_count_next = sample_count_reg;
    overrun_next      = overrun_reg;
    drop_count_next   = drop_count_reg;
    start_frame       = 1'b0;
    store_en          = 1'b0;
    clear_frame       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arm) state_next = HUNT;
        else     overrun_next = 1'b0;
      end
      HUNT, QUAL, CAPTURE: begin
        if (!arm) begin
          // Disarm discards any partial frame, even on the final capture tick.
          state_next        = IDLE;
          sample_count_next = 8'd0;
          clear_frame       = 1'b1;
        end else if (sample_tick) begin
          if (state_reg == HUNT) begin
            if (rx_signal) begin
              start_frame       = 1'b1;
              sample_count_next = 8'd1;
              state_next        = (QUAL_TICKS == 1) ? CAPTURE : QUAL;
            end
          end else if (state_reg == QUAL && !rx_signal) begin
            state_next        = HUNT;
            sample_count_next = 8'd0;
            clear_frame       = 1'b1;
          end else begin
            store_en          = 1'b1;
            sample_count_next = count_inc;
            if (count_inc == FULL_COUNT) begin
              state_next       = HOLD;
              frame_valid_next = 1'b1;
            end else if (state_reg == QUAL && count_inc == QUAL_COUNT) begin
              state_next = CAPTURE;
            end
          end
        end
      end
      HOLD: begin
        if (sample_tick && rx_signal && !prev_rx_reg) begin
          overrun_next = 1'b1;
          if (drop_count_reg != {DROP_W{1'b1}}) drop_count_next = drop_count_reg + 1'b1;
        end
        if (frame_ready) begin
          frame_valid_next  = 1'b0;
          sample_count_next = 8'd0;
          state_next        = arm ? HUNT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit gi holds sample number SAMPLES-1-gi; first sample lands in the MSB.
  for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_frame_bit
    localparam logic [7:0] POS = 8'(SAMPLES - 1 - gi);
    assign frame_data_next[gi] = clear_frame ? 1'b0 :
                                 start_frame ? (gi == SAMPLES - 1) :
                                 (store_en && sample_count_reg == POS) ? rx_signal :
                                 frame_data_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      frame_data_reg   <= '0;
      frame_valid_reg  <= 1'b0;
      sample_count_reg <= 8'd0;
      overrun_reg      <= 1'b0;
      drop_count_reg   <= '0;
      prev_rx_reg      <= 1'b1;
    end else begin
      state_reg        <= state_next;
      frame_data_reg   <= frame_data_next;
      frame_valid_reg  <= frame_valid_next;
      sample_count_reg <= sample_count_next;
      overrun_reg      <= overrun_next;
      drop_count_reg   <= drop_count_next;
      if (sample_tick) prev_rx_reg <= rx_signal;
    end
  end

  assign frame_data   = frame_data_reg;
  assign frame_valid  = frame_valid_reg;
  assign busy         = (state_reg == QUAL) || (state_reg == CAPTURE);
  assign sample_count = sample_count_reg;
  assign overrun      = overrun_reg;
  assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_rx_sample_sequencer.sv
// Bench for rx_sample_sequencer: two instances (qualify 3 / drop width 2, qualify 1 / width 8)
// share stimulus and are compared every cycle against a sample-list reference model.
module tb_rx_sample_sequencer;
  localparam int S = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0, rx_signal = 1'b0, arm = 1'b0, frame_ready = 1'b0;

  logic [S-1:0] fd_a, fd_b;
  logic         fv_a, fv_b, busy_a, busy_b, ov_a, ov_b;
  logic [7:0]   cnt_a, cnt_b;
  logic [1:0]   drop_a;
  logic [7:0]   drop_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_sample_sequencer #(.SAMPLES(S), .QUAL_TICKS(3), .DROP_W(2)) u_a (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_signal(rx_signal), .arm(arm),
    .frame_ready(frame_ready), .frame_data(fd_a), .frame_valid(fv_a), .busy(busy_a),
    .sample_count(cnt_a), .overrun(ov_a), .drop_count(drop_a));

  rx_sample_sequencer #(.SAMPLES(S), .QUAL_TICKS(1), .DROP_W(8)) u_b (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_signal(rx_signal), .arm(arm),
    .frame_ready(frame_ready), .frame_data(fd_b), .frame_valid(fv_b), .busy(busy_b),
    .sample_count(cnt_b), .overrun(ov_b), .drop_count(drop_b));

  // Reference: mode 0 = disarmed, 1 = collecting (len samples so far), 2 = holding a frame.
  int           qual_of[2];
  int           drop_max[2];
  int           m_mode[2], m_len[2], m_drop[2];
  logic [S-1:0] m_frame[2];
  bit           m_ov[2], m_prev[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_len[i] = 0; m_drop[i] = 0; m_frame[i] = '0; m_ov[i] = 0; m_prev[i] = 1;
    end
  endtask

  task automatic model_step(input bit a, input bit t, input bit r, input bit rd);
    for (int i = 0; i < 2; i++) begin
      case (m_mode[i])
        0: if (a) m_mode[i] = 1; else m_ov[i] = 0;
        1: begin
          if (!a) begin
            m_mode[i] = 0; m_len[i] = 0; m_frame[i] = '0;
          end else if (t) begin
            if (m_len[i] > 0 && m_len[i] < qual_of[i] && !r) begin
              m_len[i] = 0; m_frame[i] = '0;
            end else if (m_len[i] > 0 || r) begin
              if (m_len[i] == 0) m_frame[i] = '0;
              if (r) m_frame[i] = m_frame[i] | (S'(1) << (S - 1 - m_len[i]));
              else   m_frame[i] = m_frame[i] & ~(S'(1) << (S - 1 - m_len[i]));
              m_len[i]++;
              if (m_len[i] == S) m_mode[i] = 2;
            end
          end
        end
        default: begin
          if (t && r && !m_prev[i]) begin
            m_ov[i] = 1;
            if (m_drop[i] < drop_max[i]) m_drop[i]++;
          end
          if (rd) begin
            m_len[i] = 0; m_mode[i] = a ? 1 : 0;
          end
        end
      endcase
      if (t) m_prev[i] = r;
    end
  endtask

  task automatic check_all();
    chk("a_valid", 32'(fv_a), 32'(m_mode[0] == 2));
    chk("a_busy",  32'(busy_a), 32'(m_mode[0] == 1 && m_len[0] > 0));
    chk("a_count", 32'(cnt_a), 32'(m_len[0]));
    chk("a_frame", 32'(fd_a), 32'(m_frame[0]));
    chk("a_overrun", 32'(ov_a), 32'(m_ov[0]));
    chk("a_drop", 32'(drop_a), 32'(m_drop[0]));
    chk("b_valid", 32'(fv_b), 32'(m_mode[1] == 2));
    chk("b_busy",  32'(busy_b), 32'(m_mode[1] == 1 && m_len[1] > 0));
    chk("b_count", 32'(cnt_b), 32'(m_len[1]));
    chk("b_frame", 32'(fd_b), 32'(m_frame[1]));
    chk("b_overrun", 32'(ov_b), 32'(m_ov[1]));
    chk("b_drop", 32'(drop_b), 32'(m_drop[1]));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_a_frame"}, 32'(fd_a), 32'd0);
    chk({tag, "_a_valid"}, 32'(fv_a), 32'd0);
    chk({tag, "_a_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_a_count"}, 32'(cnt_a), 32'd0);
    chk({tag, "_a_overrun"}, 32'(ov_a), 32'd0);
    chk({tag, "_a_drop"}, 32'(drop_a), 32'd0);
    chk({tag, "_b_frame"}, 32'(fd_b), 32'd0);
    chk({tag, "_b_valid"}, 32'(fv_b), 32'd0);
    chk({tag, "_b_overrun"}, 32'(ov_b), 32'd0);
    chk({tag, "_b_drop"}, 32'(drop_b), 32'd0);
  endtask

  task automatic cycle(input bit a, input bit t, input bit r, input bit rd);
    @(negedge clk);
    arm = a; sample_tick = t; rx_signal = r; frame_ready = rd;
    model_step(a, t, r, rd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic sample(input bit a, input bit r, input bit rd);
    cycle(a, 1'b0, r, rd);
    cycle(a, 1'b0, r, rd);
    cycle(a, 1'b1, r, rd);
  endtask

  initial begin
    logic [S-1:0] pat;
    qual_of[0] = 3; qual_of[1] = 1; drop_max[0] = 3; drop_max[1] = 255;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean frame: a 1 then alternating 0/1, decoder always ready.
    cycle(1, 0, 0, 1);
    sample(1, 1, 1);
    for (int k = 1; k < S; k++) sample(1, k[0] ? 1'b0 : 1'b1, 1);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1);

    // Glitch 1,1,0 then 1,1,1 and zeros.
    pat = 16'b1100_0000_0000_0000;
    for (int k = 0; k < 3; k++) sample(1, pat[S-1-k], 1);
    for (int k = 0; k < S; k++) sample(1, (k < 3) ? 1'b1 : 1'b0, 1);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1);

    // Backpressure: capture with ready low, then five 0->1 edges while holding.
    for (int k = 0; k < S; k++) sample(1, (k < 3) ? 1'b1 : 1'b0, 0);
    for (int k = 0; k < 10; k++) sample(1, k[0], 0);
    chk("sat_drop_a", 32'(drop_a), 32'd3);
    chk("drop_b_five", 32'(drop_b), 32'd5);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // Disarm mid-capture, then release the line, then a full frame after re-arming.
    for (int k = 0; k < 8; k++) sample(1, (k < 3) ? 1'b1 : k[1], 1);
    cycle(0, 0, 0, 1);
    chk("disarm_count_a", 32'(cnt_a), 32'd0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
    for (int k = 0; k < S; k++) sample(1, (k < 3) ? 1'b1 : k[0], 1);
    cycle(1, 0, 0, 1);

    // Asynchronous reset while holding a frame with overrun set.
    for (int k = 0; k < S; k++) sample(1, (k < 3) ? 1'b1 : 1'b0, 0);
    sample(1, 0, 0);
    sample(1, 1, 0);
    chk("pre_reset_ov_a", 32'(ov_a), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 30) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
